// File: rtl/sha_message_loader.sv
// sha_message_loader
//   Input-side front end for the SHA-256 hasher. Builds the message from
//   board switches: debounces the load/commit/clear buttons, shifts one byte
//   per load into a MSG_BYTES-byte register, raises start to the hasher and
//   keeps the message frozen until the hash has completed and been cleared.
//
// Optional feature macro: LOADER_BACKSPACE_EN
//   When defined, adds i_del_btn, a debounced backspace that drops the most
//   recently loaded byte while in IDLE.
//
// Ports
//   i_clk          block clock (same enable clock that drives the hasher)
//   i_reset        synchronous, active-high reset
//   i_data_in      byte to load (from sw[7:0])
//   i_load_btn     raw button: append i_data_in
//   i_commit_btn   raw button: start hashing (only when full)
//   i_clear_btn    raw button: empty the buffer
//   i_del_btn      raw button: backspace (LOADER_BACKSPACE_EN only)
//   i_hash_done    level from hasher: hash valid
//   o_message      message to hasher, first byte loaded in the MSBs
//   o_byte_count   bytes currently loaded
//   o_full         o_byte_count == MSG_BYTES
//   o_start        to hasher; high in START and WAIT
//   o_busy         high in START and WAIT
//   o_done         high in DONE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | collecting bytes; load/clear/commit (and del) accepted
// START | one cycle after an accepted commit; start raised
// WAIT  | hash in flight; message frozen, clear ignored
// DONE  | hash valid; message frozen until clear

// Button debouncer: two-flop synchronizer, then a down-counter that reloads
// on every change of the synchronized level. The accepted level follows the
// raw level once the counter has run out; the event is its rising edge.
module sha_loader_debounce #(
  parameter int CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_event
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_raw_q;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync    <= 2'b00;
      r_raw_q   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_level_q <= r_level;
      if (r_sync[1] != r_raw_q) begin
        r_raw_q <= r_sync[1];
        r_cnt   <= CW'(CYCLES - 1);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_level <= r_raw_q;
      end
    end
  end

  assign o_event = r_level & ~r_level_q;
endmodule

module sha_message_loader #(
  parameter int MSG_BYTES       = 15,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [7:0]                     i_data_in,
  input  logic                           i_load_btn,
  input  logic                           i_commit_btn,
  input  logic                           i_clear_btn,
`ifdef LOADER_BACKSPACE_EN
  input  logic                           i_del_btn,
`endif
  input  logic                           i_hash_done,
  output logic [8*MSG_BYTES-1:0]         o_message,
  output logic [$clog2(MSG_BYTES+1)-1:0] o_byte_count,
  output logic                           o_full,
  output logic                           o_start,
  output logic                           o_busy,
  output logic                           o_done
);
  localparam int MW   = 8 * MSG_BYTES;
  localparam int CNTW = $clog2(MSG_BYTES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [MW-1:0]   r_message;
  logic [CNTW-1:0] r_count;
  logic            r_start;
  logic            r_busy;
  logic            r_done;

  logic w_load_evt;
  logic w_commit_evt;
  logic w_clear_evt;
  logic w_full;

  sha_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_load_btn), .o_event(w_load_evt)
  );
  sha_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
    .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_commit_btn), .o_event(w_commit_evt)
  );
  sha_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_clear_btn), .o_event(w_clear_evt)
  );

`ifdef LOADER_BACKSPACE_EN
  logic w_del_evt;
  sha_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_del (
    .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_del_btn), .o_event(w_del_evt)
  );
`endif

  assign w_full = (r_count == CNTW'(MSG_BYTES));

  // Event priority is clear > commit > load (> del). Each condition already
  // includes its own legality, so an illegal higher-priority event falls
  // through and lets the next legal one act.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_message <= '0;
      r_count   <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_clear_evt) begin
            r_message <= '0;
            r_count   <= '0;
          end else if (w_commit_evt && w_full) begin
            r_state <= ST_START;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_load_evt && !w_full) begin
            r_message <= {r_message[MW-9:0], i_data_in};
            r_count   <= r_count + CNTW'(1);
          end
`ifdef LOADER_BACKSPACE_EN
          else if (w_del_evt && (r_count != '0)) begin
            r_message <= {8'h00, r_message[MW-1:8]};
            r_count   <= r_count - CNTW'(1);
          end
`endif
        end
        ST_START: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A level already high on entry is honoured on the first WAIT cycle.
          if (i_hash_done) begin
            r_state <= ST_DONE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_clear_evt) begin
            r_state   <= ST_IDLE;
            r_message <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_message    = r_message;
  assign o_byte_count = r_count;
  assign o_full       = w_full;
  assign o_start      = r_start;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
endmodule
